// File: rtl/de1soc_board_pkg.sv
// Board-level constants for the DE1-SoC: clock rate, key polarity and default debounce time.
package de1soc_board_pkg;
    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned DEBOUNCE_20MS  = 1_000_000;
    localparam logic        KEY_PRESSED    = 1'b0;
    localparam int unsigned NUM_BOARD_KEYS = 4;
endpackage

// File: rtl/key_debounce_channel.sv
// One push-key channel: two-flop synchroniser, stability counter and the
// level / press / release / toggle registers derived from it.
module key_debounce_channel
    import de1soc_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned CNT_W           = 20,
    parameter bit          TOGGLE_INIT     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             toggle_q, toggle_d;
    logic             raw;

    assign raw = (s2_q == KEY_PRESSED);

    // A change is accepted only after the new value has been seen for a full
    // run of DEBOUNCE_CYCLES; any return to the accepted level restarts it.
    always_comb begin
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        if (raw != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d   = raw;
                press_d   = raw;
                release_d = ~raw;
                toggle_d  = toggle_q ^ raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= ~KEY_PRESSED;
            s2_q      <= ~KEY_PRESSED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= TOGGLE_INIT;
        end else begin
            s1_q      <= key_n;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_toggle  = toggle_q;
endmodule

// File: rtl/key_debouncer.sv
// DE1-SoC push-key front end: one independent debounce channel per key,
// giving clean level, press/release pulses and a toggle flag in the clk domain.
module key_debouncer
    import de1soc_board_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned CNT_W           = 20,
    parameter bit          TOGGLE_INIT     = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_toggle
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .TOGGLE_INIT    (TOGGLE_INIT)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_toggle (key_toggle[i])
        );
    end
endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with a short debounce window (8 cycles).
module tb_key_debouncer;
    localparam int NK = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level, key_press, key_release, key_toggle;

    int total = 0;
    int bad   = 0;

    key_debouncer #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (3),
        .TOGGLE_INIT    (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_toggle (key_toggle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] kn;
        int            n;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
        logic [NK-1:0] tgl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [NK-1:0] kn, int n, logic [NK-1:0] lvl,
                                logic [NK-1:0] prs, logic [NK-1:0] rel, logic [NK-1:0] tgl);
        vec_t v;
        v.kn = kn; v.n = n; v.lvl = lvl; v.prs = prs; v.rel = rel; v.tgl = tgl;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [NK-1:0] act,
                       input logic [NK-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s idx=%0d got=%b want=%b t=%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [NK-1:0] lvl,
                           input logic [NK-1:0] prs, input logic [NK-1:0] rel,
                           input logic [NK-1:0] tgl);
        chk({tag, ".level"},   idx, key_level,   lvl);
        chk({tag, ".press"},   idx, key_press,   prs);
        chk({tag, ".release"}, idx, key_release, rel);
        chk({tag, ".toggle"},  idx, key_toggle,  tgl);
    endtask

    initial begin
        // clean press / release on key0
        vecs.push_back(mk(3'b111, 20, 3'b000, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(3'b110,  9, 3'b000, 3'b000, 3'b000, 3'b000));
        vecs.push_back(mk(3'b110,  1, 3'b001, 3'b001, 3'b000, 3'b001));
        vecs.push_back(mk(3'b110, 20, 3'b001, 3'b000, 3'b000, 3'b001));
        vecs.push_back(mk(3'b111,  9, 3'b001, 3'b000, 3'b000, 3'b001));
        vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b001, 3'b001));
        vecs.push_back(mk(3'b111,  5, 3'b000, 3'b000, 3'b000, 3'b001));
        // bouncy press on key1
        vecs.push_back(mk(3'b101,  5, 3'b000, 3'b000, 3'b000, 3'b001));
        vecs.push_back(mk(3'b111,  2, 3'b000, 3'b000, 3'b000, 3'b001));
        vecs.push_back(mk(3'b101,  1, 3'b000, 3'b000, 3'b000, 3'b001));
        vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b000, 3'b001));
        vecs.push_back(mk(3'b101,  9, 3'b000, 3'b000, 3'b000, 3'b001));
        vecs.push_back(mk(3'b101,  1, 3'b010, 3'b010, 3'b000, 3'b011));
        vecs.push_back(mk(3'b101,  5, 3'b010, 3'b000, 3'b000, 3'b011));
        vecs.push_back(mk(3'b111,  9, 3'b010, 3'b000, 3'b000, 3'b011));
        vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b010, 3'b011));
        vecs.push_back(mk(3'b111,  3, 3'b000, 3'b000, 3'b000, 3'b011));
        // 7-cycle glitch on key2 reaches the last count but is rejected
        vecs.push_back(mk(3'b011,  7, 3'b000, 3'b000, 3'b000, 3'b011));
        vecs.push_back(mk(3'b111, 10, 3'b000, 3'b000, 3'b000, 3'b011));
        // simultaneous key0+key2, twice
        vecs.push_back(mk(3'b010,  9, 3'b000, 3'b000, 3'b000, 3'b011));
        vecs.push_back(mk(3'b010,  1, 3'b101, 3'b101, 3'b000, 3'b110));
        vecs.push_back(mk(3'b010,  3, 3'b101, 3'b000, 3'b000, 3'b110));
        vecs.push_back(mk(3'b111,  9, 3'b101, 3'b000, 3'b000, 3'b110));
        vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b101, 3'b110));
        vecs.push_back(mk(3'b111,  2, 3'b000, 3'b000, 3'b000, 3'b110));
        vecs.push_back(mk(3'b010,  9, 3'b000, 3'b000, 3'b000, 3'b110));
        vecs.push_back(mk(3'b010,  1, 3'b101, 3'b101, 3'b000, 3'b011));
        vecs.push_back(mk(3'b010,  2, 3'b101, 3'b000, 3'b000, 3'b011));
        vecs.push_back(mk(3'b111,  9, 3'b101, 3'b000, 3'b000, 3'b011));
        vecs.push_back(mk(3'b111,  1, 3'b000, 3'b000, 3'b101, 3'b011));
        vecs.push_back(mk(3'b111,  2, 3'b000, 3'b000, 3'b000, 3'b011));

        // reset asserted asynchronously: outputs clear with no clock edge
        key_n   = 3'b111;
        reset_n = 1'b0;
        #1;
        chk_all("reset0", 0, 3'b000, 3'b000, 3'b000, 3'b000);
        step();
        step();
        chk_all("reset1", 0, 3'b000, 3'b000, 3'b000, 3'b000);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            key_n = vecs[i].kn;
            for (int c = 0; c < vecs[i].n; c++) begin
                step();
                chk_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].tgl);
            end
        end

        // reset while key0 is held and accepted: everything clears between edges
        key_n = 3'b110;
        for (int c = 0; c < 14; c++) step();
        chk_all("held", 0, 3'b001, 3'b000, 3'b000, 3'b010);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("midrst", 0, 3'b000, 3'b000, 3'b000, 3'b000);
        step();
        step();
        chk_all("midrst_hold", 0, 3'b000, 3'b000, 3'b000, 3'b000);
        reset_n = 1'b1;
        // key still held: press lands on the 10th edge after release of reset
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c < 10)
                chk_all("rstpress", c, 3'b000, 3'b000, 3'b000, 3'b000);
            else if (c == 10)
                chk_all("rstpress", c, 3'b001, 3'b001, 3'b000, 3'b001);
            else
                chk_all("rstpress", c, 3'b001, 3'b000, 3'b000, 3'b001);
        end

        // partial count on key1 is discarded by reset; no pulse afterwards
        key_n = 3'b101;
        for (int c = 0; c < 6; c++) step();
        reset_n = 1'b0;
        key_n   = 3'b111;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            chk_all("partial", c, 3'b000, 3'b000, 3'b000, 3'b000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
